// File: rtl/lvds_tx_arbiter.sv
// Two-requester, burst-based round-robin arbiter in front of the LVDS transmit
// enqueue port. A grant is held until the current burst ends, so a producer's
// words stay contiguous on the serial link. Grant-side outputs are decoded
// combinationally from the registered state, so data, enable and ready pass
// straight through to and from the transmitter.
//
// Handshake: a word moves on a cycle where EN and RDY are both 1. RDY_reqN_put
// may be 1 only while requester N holds the grant, and it follows RDY_tx_put.
// A producer may raise EN_reqN_put only in a cycle where it sees RDY_reqN_put
// high. reqN_valid means "I have a word pending" and may be raised before RDY.
// reqN_last qualifies the word carried by that same transfer.
module lvds_tx_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_put,
  input  logic              req0_last,
  input  logic              EN_req0_put,
  output logic              RDY_req0_put,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_put,
  input  logic              req1_last,
  input  logic              EN_req1_put,
  output logic              RDY_req1_put,
  output logic [DATA_W-1:0] tx_put,
  output logic              EN_tx_put,
  input  logic              RDY_tx_put,
  output logic [1:0]        grant,
  output logic              proto_err,
  output logic [1:0]        dbg_state,
  output logic              dbg_ptr,
  output logic [7:0]        dbg_burst_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  // Count value at which the next transfer is the last one a grant allows.
  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       proto_err_q, proto_err_d;

  logic       xfer;
  logic       cur_valid;
  logic       cur_last;
  logic       end_of_burst;

  // Preferred requester p wins if valid, otherwise the other one, else nobody.
  function automatic state_e sel_grant(input logic p, input logic v0, input logic v1);
    logic vp;
    logic vo;
    vp = p ? v1 : v0;
    vo = p ? v0 : v1;
    if (vp)      sel_grant = p ? GNT1 : GNT0;
    else if (vo) sel_grant = p ? GNT0 : GNT1;
    else         sel_grant = IDLE;
  endfunction

  // Grant-side datapath: steer the granted requester to the transmitter.
  always_comb begin
    grant        = 2'b00;
    RDY_req0_put = 1'b0;
    RDY_req1_put = 1'b0;
    EN_tx_put    = 1'b0;
    tx_put       = '0;
    cur_valid    = 1'b0;
    cur_last     = 1'b0;
    case (state_q)
      GNT0: begin
        grant        = 2'b01;
        RDY_req0_put = RDY_tx_put;
        EN_tx_put    = EN_req0_put;
        tx_put       = req0_put;
        cur_valid    = req0_valid;
        cur_last     = req0_last;
      end
      GNT1: begin
        grant        = 2'b10;
        RDY_req1_put = RDY_tx_put;
        EN_tx_put    = EN_req1_put;
        tx_put       = req1_put;
        cur_valid    = req1_valid;
        cur_last     = req1_last;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
    xfer = EN_tx_put & RDY_tx_put;
  end

  // Next-state logic: burst accounting, end-of-burst detection and handover.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    burst_cnt_d  = burst_cnt_q;
    end_of_burst = 1'b0;
    // Sticky protocol monitor: EN without RDY, or both producers enabling at once.
    proto_err_d  = proto_err_q
                 | (EN_req0_put & ~RDY_req0_put)
                 | (EN_req1_put & ~RDY_req1_put)
                 | (EN_req0_put & EN_req1_put);
    case (state_q)
      IDLE: begin
        burst_cnt_d = 8'd0;
        state_d     = sel_grant(ptr_q, req0_valid, req1_valid);
      end
      GNT0, GNT1: begin
        // A stalled transmitter never ends a burst unless the owner walks away.
        end_of_burst = (xfer & (cur_last | (burst_cnt_q == LAST_CNT)))
                     | (~xfer & ~cur_valid);
        if (end_of_burst) begin
          ptr_d       = (state_q == GNT0);
          burst_cnt_d = 8'd0;
          state_d     = sel_grant(state_q == GNT0, req0_valid, req1_valid);
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  // State registers; reset aborts any burst in flight immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      burst_cnt_q <= 8'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err     = proto_err_q;
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;
  assign dbg_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// Directed bench for lvds_tx_arbiter with a small burst limit (4) so that
// limit-driven handovers are reached within a few cycles.
module tb_lvds_tx_arbiter;

  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              CLK;
  logic              RST_N;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_put;
  logic              req0_last;
  logic              EN_req0_put;
  logic              RDY_req0_put;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_put;
  logic              req1_last;
  logic              EN_req1_put;
  logic              RDY_req1_put;
  logic [DATA_W-1:0] tx_put;
  logic              EN_tx_put;
  logic              RDY_tx_put;
  logic [1:0]        grant;
  logic              proto_err;
  logic [1:0]        dbg_state;
  logic              dbg_ptr;
  logic [7:0]        dbg_burst_cnt;

  int errors = 0;
  int checks = 0;

  lvds_tx_arbiter #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .req0_valid    (req0_valid),
    .req0_put      (req0_put),
    .req0_last     (req0_last),
    .EN_req0_put   (EN_req0_put),
    .RDY_req0_put  (RDY_req0_put),
    .req1_valid    (req1_valid),
    .req1_put      (req1_put),
    .req1_last     (req1_last),
    .EN_req1_put   (EN_req1_put),
    .RDY_req1_put  (RDY_req1_put),
    .tx_put        (tx_put),
    .EN_tx_put     (EN_tx_put),
    .RDY_tx_put    (RDY_tx_put),
    .grant         (grant),
    .proto_err     (proto_err),
    .dbg_state     (dbg_state),
    .dbg_ptr       (dbg_ptr),
    .dbg_burst_cnt (dbg_burst_cnt)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid  = 1'b0;
    req0_put    = '0;
    req0_last   = 1'b0;
    EN_req0_put = 1'b0;
    req1_valid  = 1'b0;
    req1_put    = '0;
    req1_last   = 1'b0;
    EN_req1_put = 1'b0;
    RDY_tx_put  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // Reset values of every output
  task automatic test_reset();
    clear_inputs();
    RST_N = 1'b0;
    #3;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (RDY_req0_put !== 1'b0 || RDY_req1_put !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b%b exp=00", RDY_req1_put, RDY_req0_put); end
    checks++; if (EN_tx_put !== 1'b0) begin errors++; $display("FAIL reset_en_tx got=%b exp=0", EN_tx_put); end
    checks++; if (tx_put !== 32'h0) begin errors++; $display("FAIL reset_tx_put got=%h exp=0", tx_put); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    checks++; if (dbg_state !== 2'd0 || dbg_ptr !== 1'b0 || dbg_burst_cnt !== 8'd0) begin errors++; $display("FAIL reset_regs got state=%0d ptr=%b cnt=%0d exp 0/0/0", dbg_state, dbg_ptr, dbg_burst_cnt); end
  endtask

  // Both requesters always valid: 4-word bursts alternate with no bubble
  task automatic test_round_robin();
    logic [1:0]        exp_g;
    logic [DATA_W-1:0] exp_w;
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    RDY_tx_put = 1'b1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_idle_grant got=%b exp=00", grant); end
    tick();
    for (int i = 0; i < 12; i++) begin
      exp_g       = (i < 4) ? 2'b01 : (i < 8) ? 2'b10 : 2'b01;
      req0_put    = 32'hA000_0000 + 32'(i);
      req1_put    = 32'hB000_0000 + 32'(i);
      EN_req0_put = (exp_g == 2'b01);
      EN_req1_put = (exp_g == 2'b10);
      exp_w       = (exp_g == 2'b01) ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i);
      #1;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant, exp_g); end
      checks++; if (EN_tx_put !== 1'b1 || tx_put !== exp_w) begin errors++; $display("FAIL rr_word[%0d] got en=%b data=%h exp en=1 data=%h", i, EN_tx_put, tx_put, exp_w); end
      tick();
    end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rr_proto_err got=%b exp=0", proto_err); end
  endtask

  // req1 alone sends a 3-word burst ending with last, then is re-granted
  task automatic test_solo_burst();
    do_reset();
    req1_valid = 1'b1;
    RDY_tx_put = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      req1_put    = 32'hC000_0000 + 32'(i);
      req1_last   = (i == 2);
      EN_req1_put = 1'b1;
      #1;
      checks++; if (grant !== 2'b10 || RDY_req1_put !== 1'b1 || tx_put !== 32'hC000_0000 + 32'(i)) begin errors++; $display("FAIL solo_xfer[%0d] got g=%b rdy=%b data=%h exp g=10 rdy=1 data=%h", i, grant, RDY_req1_put, tx_put, 32'hC000_0000 + 32'(i)); end
      checks++; if (dbg_burst_cnt !== 8'(i)) begin errors++; $display("FAIL solo_cnt[%0d] got=%0d exp=%0d", i, dbg_burst_cnt, i); end
      tick();
    end
    req1_last   = 1'b0;
    EN_req1_put = 1'b0;
    #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL solo_regrant got=%b exp=10", grant); end
    checks++; if (dbg_ptr !== 1'b0 || dbg_burst_cnt !== 8'd0) begin errors++; $display("FAIL solo_ptr_cnt got ptr=%b cnt=%0d exp ptr=0 cnt=0", dbg_ptr, dbg_burst_cnt); end
  endtask

  // Transmitter stalls for 5 cycles mid-burst under GNT0
  task automatic test_stall();
    do_reset();
    req0_valid = 1'b1;
    RDY_tx_put = 1'b1;
    tick();
    EN_req0_put = 1'b1;
    req0_put    = 32'h1111_0000;
    tick();
    req0_put    = 32'h1111_0001;
    tick();
    RDY_tx_put  = 1'b0;
    EN_req0_put = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (RDY_req0_put !== 1'b0 || EN_tx_put !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL stall[%0d] got rdy=%b en=%b g=%b exp rdy=0 en=0 g=01", i, RDY_req0_put, EN_tx_put, grant); end
      checks++; if (dbg_burst_cnt !== 8'd2) begin errors++; $display("FAIL stall_cnt[%0d] got=%0d exp=2", i, dbg_burst_cnt); end
      tick();
    end
    RDY_tx_put  = 1'b1;
    EN_req0_put = 1'b1;
    req0_put    = 32'h1111_0002;
    #1;
    checks++; if (RDY_req0_put !== 1'b1 || EN_tx_put !== 1'b1 || tx_put !== 32'h1111_0002) begin errors++; $display("FAIL stall_resume got rdy=%b en=%b data=%h exp rdy=1 en=1 data=11110002", RDY_req0_put, EN_tx_put, tx_put); end
    tick();
    EN_req0_put = 1'b0;
    #1;
    checks++; if (dbg_burst_cnt !== 8'd3 || proto_err !== 1'b0) begin errors++; $display("FAIL stall_after got cnt=%0d perr=%b exp cnt=3 perr=0", dbg_burst_cnt, proto_err); end
  endtask

  // Non-granted EN is never forwarded and latches proto_err until reset
  task automatic test_proto_err();
    do_reset();
    req0_valid  = 1'b1;
    RDY_tx_put  = 1'b1;
    tick();
    EN_req1_put = 1'b1;
    req1_put    = 32'hDEAD_BEEF;
    req0_put    = 32'h2222_0000;
    #1;
    checks++; if (EN_tx_put !== 1'b0) begin errors++; $display("FAIL perr_no_fwd got=%b exp=0", EN_tx_put); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_early got=%b exp=0", proto_err); end
    EN_req0_put = 1'b1;
    #1;
    checks++; if (EN_tx_put !== 1'b1 || tx_put !== 32'h2222_0000) begin errors++; $display("FAIL perr_fwd0 got en=%b data=%h exp en=1 data=22220000", EN_tx_put, tx_put); end
    tick();
    EN_req0_put = 1'b0;
    EN_req1_put = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set got=%b exp=1", proto_err); end
    repeat (3) tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
    RST_N = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear got=%b exp=0", proto_err); end
  endtask

  // Owner drops valid with no transfer while the other side waits
  task automatic test_abandon();
    do_reset();
    req0_valid  = 1'b1;
    req1_valid  = 1'b1;
    RDY_tx_put  = 1'b1;
    tick();
    EN_req0_put = 1'b1;
    req0_put    = 32'h3333_0000;
    tick();
    EN_req0_put = 1'b0;
    req0_valid  = 1'b0;
    #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL abandon_hold got=%b exp=01", grant); end
    tick();
    checks++; if (grant !== 2'b10 || RDY_req1_put !== 1'b1) begin errors++; $display("FAIL abandon_switch got g=%b rdy1=%b exp g=10 rdy1=1", grant, RDY_req1_put); end
    checks++; if (dbg_ptr !== 1'b1 || dbg_burst_cnt !== 8'd0) begin errors++; $display("FAIL abandon_regs got ptr=%b cnt=%0d exp ptr=1 cnt=0", dbg_ptr, dbg_burst_cnt); end
  endtask

  // Reset asserted between clock edges mid-burst
  task automatic test_async_reset();
    do_reset();
    req0_valid  = 1'b1;
    RDY_tx_put  = 1'b1;
    tick();
    EN_req0_put = 1'b1;
    req0_put    = 32'h4444_0000;
    tick();
    req0_put    = 32'h4444_0001;
    #1;
    checks++; if (EN_tx_put !== 1'b1 || grant !== 2'b01 || dbg_burst_cnt !== 8'd1) begin errors++; $display("FAIL async_pre got en=%b g=%b cnt=%0d exp en=1 g=01 cnt=1", EN_tx_put, grant, dbg_burst_cnt); end
    RST_N = 1'b0;
    #1;
    checks++; if (grant !== 2'b00 || RDY_req0_put !== 1'b0 || EN_tx_put !== 1'b0 || tx_put !== 32'h0) begin errors++; $display("FAIL async_outs got g=%b rdy0=%b en=%b data=%h exp g=00 rdy0=0 en=0 data=0", grant, RDY_req0_put, EN_tx_put, tx_put); end
    checks++; if (dbg_state !== 2'd0 || dbg_burst_cnt !== 8'd0 || dbg_ptr !== 1'b0) begin errors++; $display("FAIL async_regs got state=%0d cnt=%0d ptr=%b exp 0/0/0", dbg_state, dbg_burst_cnt, dbg_ptr); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_solo_burst();
    test_stall();
    test_proto_err();
    test_abandon();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
